// File: rtl/uncache_store_buffer.sv
// Uncached access engine between the CPU uncache port and one AXI slave port.
// Stores are posted into a small FIFO and drained as single-beat AXI writes.
// Loads are issued as single-beat AXI reads only after every earlier store
// has received its B response, which keeps device-register accesses ordered.
module uncache_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  AXI_ID = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  // CPU uncache port
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] data,
  input  logic        req,
  input  logic        wreq,
  input  logic [3:0]  wbyte,
  output logic        ok,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_B
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } r_state_e;

  // AXI size encoding derived from how many byte lanes a store touches.
  function automatic logic [2:0] size_from_strb(input logic [3:0] strb);
    logic [2:0] size;
    case ($countones(strb))
      1:       size = 3'd0;
      2:       size = 3'd1;
      default: size = 3'd2;
    endcase
    return size;
  endfunction

  // Store FIFO storage
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [3:0]  mem_strb [DEPTH];

  // FIFO bookkeeping
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Drain FSM state and AW/W/B registers
  w_state_e      w_state_q, w_state_d;
  logic [31:0]   awaddr_q, awaddr_d;
  logic [2:0]    awsize_q, awsize_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;

  // Read FSM state and AR/R registers
  r_state_e      r_state_q, r_state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [31:0]   data_q, data_d;

  // CPU completion pulse
  logic          ok_q, ok_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          load_start;

  // Response fields the engine deliberately does not look at.
  logic          unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A store is taken only when the read side is idle so a load in flight
  // cannot be overtaken; the !ok term stops the held req from double-pushing.
  assign push = req & wreq & ~full & ~ok_q & (r_state_q == R_IDLE);

  // The head entry stays counted until its B arrives, so empty also means
  // no write is outstanding on the bus.
  assign pop = (w_state_q == W_B) & bvalid;

  assign load_start = req & ~wreq & ~ok_q & empty &
                      (w_state_q == W_IDLE) & (r_state_q == R_IDLE);

  // FIFO pointer and occupancy update
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM: issue the head entry on AW and W, then wait for its B
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    case (w_state_q)
      W_IDLE: begin
        if (!empty) begin
          awaddr_d  = mem_addr[rd_ptr_q];
          wdata_d   = mem_data[rd_ptr_q];
          wstrb_d   = mem_strb[rd_ptr_q];
          awsize_d  = size_from_strb(mem_strb[rd_ptr_q]);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_SEND;
        end
      end
      W_SEND: begin
        // AW and W complete independently; move on once both are done.
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          w_state_d = W_B;
        end
      end
      W_B: begin
        if (bvalid) begin
          bready_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Read FSM: single-beat load once all buffered stores have retired
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    data_d    = data_q;
    case (r_state_q)
      R_IDLE: begin
        if (load_start) begin
          araddr_d  = addr;
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_R;
        end
      end
      R_R: begin
        if (rvalid) begin
          data_d    = rdata;
          rready_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // One-cycle completion: a store when it is buffered, a load when R arrives
  assign ok_d = push | ((r_state_q == R_R) & rvalid);

  // Control and datapath registers, cleared asynchronously to abort any
  // transaction in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      data_q    <= '0;
      ok_q      <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register sees the values from before this edge.
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      data_q    <= data_d;
      ok_q      <= ok_d;
    end
  end

  // FIFO entry write on store accept
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; clearing count_q on reset makes
    // any stale entries unreachable, so resetting the array buys nothing.
    if (push) begin
      mem_addr[wr_ptr_q] <= addr;
      mem_data[wr_ptr_q] <= din;
      mem_strb[wr_ptr_q] <= wbyte;
    end
  end

  // Registered outputs
  assign data    = data_q;
  assign ok      = ok_q;
  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Fixed single-beat, incrementing, normal, non-cacheable attributes
  assign arid    = AXI_ID;
  assign arlen   = 4'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = AXI_ID;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_uncache_store_buffer.sv
// Directed bench for uncache_store_buffer: a CPU-side sequence in one initial
// block plus a small AXI slave responder with adjustable per-channel delays.
module tb_uncache_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, data;
  logic        req, wreq, ok;
  logic [3:0]  wbyte;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_assert = 0;
  int n_fail   = 0;

  // Responder knobs and logs
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_count = 0, w_count = 0, b_count = 0, ar_count = 0;
  logic [31:0] r_value = 32'h0;
  logic [31:0] wr_addr_log[$];
  logic [2:0]  wr_size_log[$];
  logic [31:0] wr_data_log[$];
  logic [3:0]  wr_strb_log[$];
  logic [31:0] ar_addr_log;
  logic [2:0]  ar_size_log;

  always #5 clk = ~clk;

  uncache_store_buffer #(.DEPTH(4), .AXI_ID(4'd2)) dut (
    .clk(clk), .rst(rst),
    .addr(addr), .din(din), .data(data), .req(req), .wreq(wreq),
    .wbyte(wbyte), .ok(ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  assign rid   = 4'd2;
  assign rresp = 2'b00;
  assign rlast = 1'b1;
  assign bid   = 4'd2;
  assign bresp = 2'b00;

  // AXI slave model: acts on the falling edge, each ready/valid held for one
  // rising edge so every raise is exactly one handshake.
  always @(negedge clk) begin
    if (rst) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      rdata = 32'h0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      if (awready) begin
        awready = 1'b0; aw_count++;
      end else if (awvalid) begin
        if (aw_wait >= aw_delay) begin
          awready = 1'b1; aw_wait = 0;
          wr_addr_log.push_back(awaddr); wr_size_log.push_back(awsize);
        end else aw_wait++;
      end
      if (wready) begin
        wready = 1'b0; w_count++;
      end else if (wvalid) begin
        if (w_wait >= w_delay) begin
          wready = 1'b1; w_wait = 0;
          wr_data_log.push_back(wdata); wr_strb_log.push_back(wstrb);
        end else w_wait++;
      end
      if (bvalid) begin
        bvalid = 1'b0; b_count++;
      end else if (bready) begin
        if (b_wait >= b_delay) begin bvalid = 1'b1; b_wait = 0; end
        else b_wait++;
      end
      if (arready) begin
        arready = 1'b0; ar_count++;
      end else if (arvalid) begin
        if (ar_wait >= ar_delay) begin
          arready = 1'b1; ar_wait = 0;
          ar_addr_log = araddr; ar_size_log = arsize;
        end else ar_wait++;
      end
      if (rvalid) begin
        rvalid = 1'b0;
      end else if (rready) begin
        if (r_wait >= r_delay) begin rvalid = 1'b1; rdata = r_value; r_wait = 0; end
        else r_wait++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one CPU request and hold it until ok; cyc is edges until ok seen.
  task automatic cpu_req(input logic is_store, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int cyc);
    addr = a; din = d; wbyte = s; wreq = is_store; req = 1'b1; cyc = 0;
    do begin
      step();
      cyc++;
    end while (!ok && cyc < 200);
    req = 1'b0;
  endtask

  task automatic wait_b(input string tag, input int target);
    int n = 0;
    while (b_count < target && n < 400) begin
      step();
      n++;
    end
    check(tag, 64'(b_count), 64'(target));
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_size_log.delete();
    wr_data_log.delete(); wr_strb_log.delete();
  endtask

  initial begin
    int cyc;
    int cycs[5];
    int base, base_aw, base_w;
    int n;
    logic early;

    rst = 1'b1; req = 1'b0; wreq = 1'b0; addr = '0; din = '0; wbyte = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    rdata = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state and constant attributes
    check("rst_ok", 64'(ok), 64'h0);
    check("rst_data", 64'(data), 64'h0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, rready, bready}), 64'h0);
    check("rst_addrs", {awaddr, araddr}, 64'h0);
    check("const_attrs",
          64'({arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache,
               arprot, awprot, wlast, arid, awid, wid, arsize}),
          64'({4'd0, 4'd0, 2'b01, 2'b01, 2'd0, 2'd0, 4'd0, 4'd0,
               3'd0, 3'd0, 1'b1, 4'd2, 4'd2, 4'd2, 3'd2}));
    rst = 1'b0;
    step();

    // Single word store
    clear_logs();
    b_delay = 3;
    cpu_req(1'b1, 32'hBFAF_F000, 32'h1234_5678, 4'hF, cyc);
    check("st1_latency", 64'(cyc), 64'd1);
    step();
    check("st1_ok_one_cycle", 64'(ok), 64'h0);
    step();
    check("st1_bready", 64'(bready), 64'h1);
    step();
    check("st1_bready_hold", 64'(bready), 64'h1);
    wait_b("st1_b", 1);
    check("st1_bready_drop", 64'(bready), 64'h0);
    check("st1_awaddr", 64'(wr_addr_log[0]), 64'hBFAF_F000);
    check("st1_awsize", 64'(wr_size_log[0]), 64'd2);
    check("st1_wdata", 64'(wr_data_log[0]), 64'h1234_5678);
    check("st1_wstrb", 64'(wr_strb_log[0]), 64'hF);

    // Byte and halfword stores
    clear_logs();
    b_delay = 0;
    base = b_count;
    cpu_req(1'b1, 32'hBFAF_F002, 32'h00AB_0000, 4'b0100, cyc);
    check("byte_ok", 64'(ok), 64'h1);
    cpu_req(1'b1, 32'hBFAF_F004, 32'h0000_CDEF, 4'b0011, cyc);
    wait_b("byte_half_b", base + 2);
    check("byte_awaddr", 64'(wr_addr_log[0]), 64'hBFAF_F002);
    check("byte_awsize", 64'(wr_size_log[0]), 64'd0);
    check("byte_wstrb", 64'(wr_strb_log[0]), 64'h4);
    check("half_awsize", 64'(wr_size_log[1]), 64'd1);

    // Five back-to-back stores into a four-entry FIFO with slow B
    clear_logs();
    b_delay = 20;
    base = b_count;
    for (int i = 0; i < 5; i++) begin
      cpu_req(1'b1, 32'hBFAF_F100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, cycs[i]);
    end
    check("full_ok5", 64'(ok), 64'h1);
    check("full_lat0", 64'(cycs[0]), 64'd1);
    check("full_lat1", 64'(cycs[1]), 64'd2);
    check("full_lat2", 64'(cycs[2]), 64'd2);
    check("full_lat3", 64'(cycs[3]), 64'd2);
    check("full_stall5", 64'(cycs[4] > 10), 64'h1);
    check("full_b_at_5th", 64'(b_count - base), 64'd1);
    wait_b("full_b_all", base + 5);
    for (int i = 0; i < 5; i++) begin
      check("full_order_addr", 64'(wr_addr_log[i]), 64'(32'hBFAF_F100 + 32'(4 * i)));
      check("full_order_data", 64'(wr_data_log[i]), 64'(32'hA000_0000 + 32'(i)));
    end

    // Store followed by a load: the read must wait for the store's B
    b_delay = 10;
    r_delay = 2;
    r_value = 32'hDEAD_BEEF;
    base = b_count;
    cpu_req(1'b1, 32'hBFAF_F00C, 32'h55AA_55AA, 4'hF, cyc);
    addr = 32'hBFAF_F010; wreq = 1'b0; req = 1'b1;
    early = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (arvalid && b_count == base) early = 1'b1;
    end while (!ok && n < 200);
    req = 1'b0;
    check("ld_after_b", 64'(early), 64'h0);
    check("ld_ok", 64'(ok), 64'h1);
    check("ld_data", 64'(data), 64'hDEAD_BEEF);
    check("ld_araddr", 64'(ar_addr_log), 64'hBFAF_F010);
    check("ld_arsize", 64'(ar_size_log), 64'd2);
    check("ld_store_done", 64'(b_count - base), 64'd1);
    step();
    check("ld_ok_one_cycle", 64'(ok), 64'h0);

    // AW accepted three cycles ahead of W
    clear_logs();
    b_delay = 0;
    w_delay = 3;
    base = b_count; base_aw = aw_count; base_w = w_count;
    cpu_req(1'b1, 32'hBFAF_F020, 32'h0BAD_F00D, 4'hF, cyc);
    n = 0;
    do begin
      step();
      n++;
    end while (!awvalid && n < 10);
    check("split_aw_rise", 64'({awvalid, wvalid}), 64'h3);
    step();
    check("split_aw_drop", 64'({awvalid, wvalid}), 64'h1);
    step();
    step();
    check("split_w_hold", 64'(wvalid), 64'h1);
    step();
    check("split_w_drop", 64'(wvalid), 64'h0);
    wait_b("split_b", base + 1);
    repeat (5) step();
    check("split_one_aw", 64'(aw_count - base_aw), 64'd1);
    check("split_one_w", 64'(w_count - base_w), 64'd1);
    check("split_wdata", 64'(wr_data_log[0]), 64'h0BAD_F00D);
    w_delay = 0;

    // Reset while waiting for B with two entries buffered
    b_delay = 1000;
    cpu_req(1'b1, 32'hBFAF_F030, 32'h1111_1111, 4'hF, cyc);
    cpu_req(1'b1, 32'hBFAF_F034, 32'h2222_2222, 4'hF, cyc);
    n = 0;
    while (!bready && n < 20) begin
      step();
      n++;
    end
    check("mid_in_wb", 64'(bready), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, ok}), 64'h0);
    check("mid_rst_awaddr", 64'(awaddr), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_delay = 0;
    base_aw = aw_count;
    repeat (30) step();
    check("mid_no_traffic", 64'({aw_count - base_aw, 31'(awvalid)}), 64'h0);
    r_value = 32'h1357_9BDF;
    cpu_req(1'b0, 32'hBFAF_F040, 32'h0, 4'h0, cyc);
    check("mid_fifo_empty_ld", 64'({ok, data}), 64'({1'b1, 32'h1357_9BDF}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
